scope_trace_renderer: RTL and testbench

Upstream pixel source for the 1280x1024 @ 108 MHz VGA timing stage. Captures a triggered record of ADC samples into a double-buffered line store and, for each pixel coordinate the timing stage presents, returns the RGB value: trace, graticule or background. Sync signals are delayed so they stay aligned with the colour outputs.

---
 rtl/scope_pkg.sv | 31 +++
 rtl/scope_line_ram.sv | 34 +++
 rtl/scope_trace_renderer.sv | 238 +++++++++++++++++++++++
 tb/tb_scope_trace_renderer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scope_pkg
// Description : Shared constants, colours and capture state type for the
//               oscilloscope trace renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package scope_pkg;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_V_ACTIVE = 1024;
    localparam int DEF_SAMPLE_W = 8;

    // Width of the pixel coordinates presented by the timing stage.
    localparam int PIX_W        = 11;

    // Graticule pitch is 2^GRID_LOG2 pixels in both directions.
    localparam int GRID_LOG2    = 7;

    localparam logic [23:0] TRACE_RGB = 24'hFF_FF_00;
    localparam logic [23:0] GRID_RGB  = 24'h40_40_40;

    typedef enum logic [1:0] {
        ARM       = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/scope_line_ram.sv
`default_nettype none
// ============================================================================
// Module      : scope_line_ram
// Description : Simple dual-port line store, one write port, one registered
//               (1-cycle) read port. No reset on the array.
// Revision    : 1.0 - initial release
// ============================================================================
module scope_line_ram
    import scope_pkg::*;
#(
    parameter int DEPTH = DEF_H_ACTIVE,
    parameter int WIDTH = DEF_SAMPLE_W,
    parameter int AW    = PIX_W
) (
    input  logic             clock,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port and synchronous read port.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/scope_trace_renderer.sv
`default_nettype none
// ============================================================================
// Module      : scope_trace_renderer
// Description : Triggered ADC record capture into a double-buffered line
//               store, plus a 2-stage pixel pipeline that renders trace,
//               optional graticule and background for the VGA timing stage.
//               Optional feature macro: SCOPE_GRID_EN (draws graticule).
// Revision    : 1.0 - initial release
// ============================================================================
module scope_trace_renderer
    import scope_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int SAMPLE_W     = DEF_SAMPLE_W,
    parameter int AUTO_TIMEOUT = 1048576
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                frame_start,
    input  logic [PIX_W-1:0]    pixel_x,
    input  logic [PIX_W-1:0]    pixel_y,
    input  logic                pixel_active,
    input  logic                hsync_in,
    input  logic                vsync_in,
    output logic [7:0]          colour_R,
    output logic [7:0]          colour_G,
    output logic [7:0]          colour_B,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic                armed
);

    // Vertical scale: one sample code spans 2^SCALE_LOG2 display rows.
    localparam int SCALE_LOG2 = $clog2(V_ACTIVE) - SAMPLE_W;
    localparam int ROW_W      = PIX_W - SCALE_LOG2;
    localparam int TO_W       = $clog2(AUTO_TIMEOUT + 1);

    cap_state_t         r_state;
    cap_state_t         w_state_next;
    logic [PIX_W-1:0]   r_wr_addr;
    logic [TO_W-1:0]    r_timeout;
    logic               r_front_sel;
    logic               r_front_valid;
    logic               w_wr_en;
    logic [PIX_W-1:0]   w_wr_addr;
    logic               w_swap;
    logic               w_trig;
    logic               w_to_hit;

    logic [SAMPLE_W-1:0] w_rd [2];

    assign armed = (r_state == ARM) || (r_state == WAIT_TRIG);

    // Capture state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, buffer write and swap decisions.
    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_wr_addr;
        w_swap       = 1'b0;
        w_trig       = (sample >= trig_level);
        w_to_hit     = (r_timeout == TO_W'(AUTO_TIMEOUT - 1));
        case (r_state)
            ARM: begin
                if (sample_valid) begin
                    if (w_to_hit) begin
                        w_wr_en      = 1'b1;
                        w_wr_addr    = '0;
                        w_state_next = CAPTURE;
                    end else if (!w_trig) begin
                        w_state_next = WAIT_TRIG;
                    end
                end
            end
            WAIT_TRIG: begin
                if (sample_valid && (w_trig || w_to_hit)) begin
                    w_wr_en      = 1'b1;
                    w_wr_addr    = '0;
                    w_state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (sample_valid) begin
                    w_wr_en = 1'b1;
                    if (r_wr_addr == PIX_W'(H_ACTIVE - 1)) begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                // A frame_start coinciding with the last write arrives while
                // still in CAPTURE, so it cannot tear the displayed record.
                if (frame_start) begin
                    w_swap       = 1'b1;
                    w_state_next = ARM;
                end
            end
            default: w_state_next = ARM;
        endcase
    end

    // Write address, timeout counter and front/back buffer selection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_addr     <= '0;
            r_timeout     <= '0;
            r_front_sel   <= 1'b0;
            r_front_valid <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_addr <= w_wr_addr + 1'b1;
            end
            if (sample_valid && armed) begin
                if (w_state_next == CAPTURE) begin
                    r_timeout <= '0;
                end else begin
                    r_timeout <= r_timeout + 1'b1;
                end
            end
            if (w_swap) begin
                r_front_sel   <= ~r_front_sel;
                r_front_valid <= 1'b1;
            end
        end
    end

    // Two line buffers; whichever is not on screen receives the capture.
    for (genvar b = 0; b < 2; b++) begin : g_buf
        scope_line_ram #(
            .DEPTH (H_ACTIVE),
            .WIDTH (SAMPLE_W),
            .AW    (PIX_W)
        ) u_ram (
            .clock   (clock),
            .i_we    (w_wr_en && (r_front_sel == (b == 0))),
            .i_waddr (w_wr_addr),
            .i_wdata (sample),
            .i_raddr (pixel_x),
            .o_rdata (w_rd[b])
        );
    end

    // Stage 1: coordinate, qualifiers and syncs aligned with the RAM read.
    logic [ROW_W-1:0] r1_row;
    logic             r1_active;
    logic             r1_x_ok;
    logic             r1_hs;
    logic             r1_vs;
    logic             r1_sel;
    logic             r1_fv;
`ifdef SCOPE_GRID_EN
    logic             r1_grid;
`endif
    logic             w_unused_ybits;

    // Sub-row bits only matter for the graticule.
    assign w_unused_ybits = ^pixel_y[SCALE_LOG2-1:0];

    // Stage 1 pipeline register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r1_row    <= '0;
            r1_active <= 1'b0;
            r1_x_ok   <= 1'b0;
            r1_hs     <= 1'b0;
            r1_vs     <= 1'b0;
            r1_sel    <= 1'b0;
            r1_fv     <= 1'b0;
`ifdef SCOPE_GRID_EN
            r1_grid   <= 1'b0;
`endif
        end else begin
            r1_row    <= pixel_y[PIX_W-1:SCALE_LOG2];
            r1_active <= pixel_active;
            r1_x_ok   <= (pixel_x < PIX_W'(H_ACTIVE));
            r1_hs     <= hsync_in;
            r1_vs     <= vsync_in;
            r1_sel    <= r_front_sel;
            r1_fv     <= r_front_valid;
`ifdef SCOPE_GRID_EN
            r1_grid   <= (pixel_x[GRID_LOG2-1:0] == '0) ||
                         (pixel_y[GRID_LOG2-1:0] == '0);
`endif
        end
    end

    logic [SAMPLE_W-1:0] w_s;
    logic [SAMPLE_W-1:0] w_inv;
    logic                w_lit;
    logic [23:0]         w_rgb;

    // Stage 2 colour selection: trace over graticule over background.
    always_comb begin
        w_s   = r1_sel ? w_rd[1] : w_rd[0];
        w_inv = ~w_s;
        w_lit = (r1_row == ROW_W'(w_inv));
        w_rgb = 24'h0;
        if (r1_active && r1_x_ok) begin
            if (w_lit && r1_fv) begin
                w_rgb = TRACE_RGB;
            end
`ifdef SCOPE_GRID_EN
            else if (r1_grid) begin
                w_rgb = GRID_RGB;
            end
`endif
        end
    end

    // Stage 2 output register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            colour_R  <= 8'h0;
            colour_G  <= 8'h0;
            colour_B  <= 8'h0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            {colour_R, colour_G, colour_B} <= w_rgb;
            hsync_out <= r1_hs;
            vsync_out <= r1_vs;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scope_trace_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scope_trace_renderer
// Description : Randomised self-checking bench for scope_trace_renderer,
//               using a record-level capture model and a pixel colour model.
//               Honours SCOPE_GRID_EN for graticule expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scope_trace_renderer;

    localparam int H  = 1280;
    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  sample;
    logic        sample_valid;
    logic [7:0]  trig_level;
    logic        frame_start;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic        pixel_active;
    logic        hsync_in;
    logic        vsync_in;
    logic [7:0]  colour_R;
    logic [7:0]  colour_G;
    logic [7:0]  colour_B;
    logic        hsync_out;
    logic        vsync_out;
    logic        armed;

    scope_trace_renderer #(
        .H_ACTIVE     (H),
        .V_ACTIVE     (1024),
        .SAMPLE_W     (8),
        .AUTO_TIMEOUT (TO)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample       (sample),
        .sample_valid (sample_valid),
        .trig_level   (trig_level),
        .frame_start  (frame_start),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .pixel_active (pixel_active),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .colour_R     (colour_R),
        .colour_G     (colour_G),
        .colour_B     (colour_B),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .armed        (armed)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_front [H];
    int          exp_back  [H];
    bit          exp_fv;
    logic [25:0] q_exp [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Colour the screen should show for a coordinate, given the record on display.
    function automatic logic [23:0] exp_colour(input int x, input int y, input bit act);
        if (!act || x >= H) return 24'h0;
        if (exp_fv && (y / 4) == (255 - exp_front[x])) return 24'hFFFF00;
`ifdef SCOPE_GRID_EN
        if ((x % 128) == 0 || (y % 128) == 0) return 24'h404040;
`endif
        return 24'h0;
    endfunction

    // Present one coordinate per cycle; compare the result two cycles later.
    task automatic pix(input int x, input int y, input bit act);
        logic        hs;
        logic        vs;
        logic [25:0] e;
        hs = 1'($urandom);
        vs = 1'($urandom);
        pixel_x      = 11'(x);
        pixel_y      = 11'(y);
        pixel_active = act;
        hsync_in     = hs;
        vsync_in     = vs;
        q_exp.push_back({exp_colour(x, y, act), hs, vs});
        tick();
        if (q_exp.size() == 2) begin
            e = q_exp.pop_front();
            check_eq("rgb", {8'h0, colour_R, colour_G, colour_B}, {8'h0, e[25:2]});
            check_eq("sync", {30'h0, hsync_out, vsync_out}, {30'h0, e[1:0]});
        end
    endtask

    task automatic pix_flush();
        pix(0, 0, 1'b0);
        q_exp.delete();
    endtask

    task automatic render_random(input int n);
        for (int i = 0; i < n; i++) begin
            int x;
            int y;
            int band;
            int m;
            bit act;
            x    = $urandom_range(0, H - 1);
            band = 4 * (255 - exp_front[x]);
            act  = 1'b1;
            m    = $urandom_range(0, 9);
            case (m)
                0, 1, 2, 3, 4, 5: y = band + $urandom_range(0, 3);
                6:       y = (band > 0) ? band - 1 : band + 4;
                7:       y = $urandom_range(0, 1023);
                8: begin
                    x = $urandom_range(H, 2047);
                    y = $urandom_range(0, 1023);
                end
                default: begin
                    act = 1'b0;
                    y   = band;
                end
            endcase
            pix(x, y, act);
        end
        pix_flush();
    endtask

    // One valid sample, preceded by a random number of idle cycles.
    task automatic drive_sample(input int s, input bit fs, input bit noise);
        while ($urandom_range(0, 3) == 0) begin
            sample_valid = 1'b0;
            sample       = 8'($urandom);
            frame_start  = noise && ($urandom_range(0, 31) == 0);
            tick();
        end
        sample_valid = 1'b1;
        sample       = 8'(s);
        frame_start  = fs;
        tick();
        sample_valid = 1'b0;
        frame_start  = 1'b0;
    endtask

    // Build a sample stream, predict which sample opens the record, capture it.
    task automatic run_record(input int mode, input int lvl, input bit collide);
        int st[$];
        int start;
        bit below;
        trig_level = 8'(lvl);
        case (mode)
            0: begin
                st = '{10, 10, 200};
                repeat (TO - 3) st.push_back($urandom_range(0, 255));
            end
            1: begin
                st.push_back(0);
                repeat (TO - 1) st.push_back(255);
            end
            2:       repeat (TO) st.push_back(0);
            3:       repeat (TO) st.push_back($urandom_range(lvl, 255));
            default: repeat (TO) st.push_back($urandom_range(0, 255));
        endcase
        start = TO - 1;
        below = 1'b0;
        for (int i = 0; i < TO; i++) begin
            if (below && st[i] >= lvl) begin
                start = i;
                break;
            end
            if (st[i] < lvl) below = 1'b1;
        end
        while (st.size() < start + H) begin
            if (mode == 1)      st.push_back(255);
            else if (mode == 2) st.push_back(0);
            else                st.push_back($urandom_range(0, 255));
        end
        for (int i = 0; i < start + H; i++) begin
            bit last;
            last = (i == start + H - 1);
            drive_sample(st[i], collide && last, !last);
            if (i <= start + 1) check_eq("armed", {31'h0, armed}, {31'h0, (i < start)});
        end
        for (int i = 0; i < H; i++) exp_back[i] = st[start + i];
        repeat (5) drive_sample($urandom_range(0, 255), 1'b0, 1'b0);
        check_eq("done_idle", {31'h0, armed}, 32'h0);
    endtask

    task automatic do_swap();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        exp_front = exp_back;
        exp_fv    = 1'b1;
        check_eq("rearm", {31'h0, armed}, 32'h1);
    endtask

    initial begin
        reset_n      = 1'b0;
        sample       = 8'h0;
        sample_valid = 1'b0;
        trig_level   = 8'h0;
        frame_start  = 1'b0;
        pixel_x      = 11'h0;
        pixel_y      = 11'h0;
        pixel_active = 1'b0;
        hsync_in     = 1'b0;
        vsync_in     = 1'b0;
        exp_fv       = 1'b0;
        for (int i = 0; i < H; i++) exp_front[i] = 0;

        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_rgb", {8'h0, colour_R, colour_G, colour_B}, 32'h0);
        check_eq("rst_sync", {30'h0, hsync_out, vsync_out}, 32'h0);
        check_eq("rst_armed", {31'h0, armed}, 32'h1);
        reset_n = 1'b1;
        tick();

        // Trigger on 200 after arming on 10; nothing shown until the swap.
        run_record(0, 100, 1'b0);
        render_random(20);
        do_swap();
        render_random(150);

        // Constant full-scale record: trace on the top four rows.
        run_record(1, 100, 1'b0);
        do_swap();
        for (int y = 0; y < 5; y++) pix(5, y, 1'b1);
        pix_flush();
        render_random(60);

        // Level never reached: timeout capture of a zero record.
        run_record(2, 100, 1'b0);
        do_swap();
        for (int y = 1019; y < 1024; y++) pix(5, y, 1'b1);
        pix(128, 7, 1'b1);
        pix(640, 128, 1'b1);
        pix_flush();
        render_random(40);

        // frame_start on the final write must not swap.
        run_record(4, $urandom_range(1, 255), 1'b1);
        render_random(60);
        do_swap();
        render_random(100);

        // Never-armed timeout and random records.
        run_record(3, $urandom_range(1, 254), 1'b0);
        do_swap();
        render_random(60);
        repeat (2) begin
            run_record(4, $urandom_range(1, 254), 1'b0);
            do_swap();
            render_random(60);
        end

        // Reset in the middle of a capture clears the displayed trace.
        trig_level = 8'd100;
        for (int i = 0; i < 300; i++) drive_sample((i == 0) ? 0 : 200, 1'b0, 1'b0);
        check_eq("mid_cap", {31'h0, armed}, 32'h0);
        reset_n = 1'b0;
        tick();
        check_eq("mid_rst_armed", {31'h0, armed}, 32'h1);
        reset_n = 1'b1;
        tick();
        exp_fv = 1'b0;
        render_random(30);
        run_record(4, 128, 1'b0);
        do_swap();
        render_random(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
